// File: rtl/keypad_entry.sv
// Scans a 4x4 active-low matrix keypad, debounces whole scan frames, and turns
// accepted keys into operand_a / operator / operand_b for the calculator.
module keypad_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] operand_a,
  output logic [4:0] operand_b,
  output logic [1:0] operator,
  output logic [1:0] entry_state,
  output logic       entry_valid,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    SHOW    = 2'b10
  } entry_t;

  typedef enum logic {
    DB_ARMED,
    DB_HELD
  } db_t;

  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [4:0] accumulate(input logic [4:0] cur, input logic [3:0] d);
    logic [8:0] wide;
    wide = 9'(cur) * 9'd10 + 9'(d);
    return (wide > 9'd31) ? 5'd31 : wide[4:0];
  endfunction

  // Row synchroniser
  logic [3:0] row_meta, row_sync;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Column scan
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             div_end, frame_end;

  assign div_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = div_end && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (div_end) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Frame accumulation: hit count saturates at 2, meaning "more than one key".
  logic [3:0] row_hits;
  logic [2:0] col_cnt, hit_sum;
  logic [3:0] col_key, frame_key, merged_key;
  logic [1:0] frame_hits, merged_hits;

  assign row_hits = ~row_sync;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    col_cnt = 3'(row_hits[0]) + 3'(row_hits[1]) + 3'(row_hits[2]) + 3'(row_hits[3]);
    col_key = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (row_hits[r]) col_key = key_at(2'(r), col_idx);
    end
    hit_sum     = 3'(frame_hits) + col_cnt;
    merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    merged_key  = (col_cnt == 3'd1) ? col_key : frame_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_hits <= 2'd0;
      frame_key  <= 4'h0;
    end else if (frame_end) begin
      frame_hits <= 2'd0;
      frame_key  <= 4'h0;
    end else if (div_end) begin
      frame_hits <= merged_hits;
      frame_key  <= merged_key;
    end
  end

  // Debounce: count qualifying frames to accept a press, then NONE frames to re-arm.
  db_t             db_state, db_next;
  logic [DB_W-1:0] db_cnt, cnt_next;
  logic [3:0]      cand_key, cand_next;
  logic            accept;

  always_comb begin
    db_next   = db_state;
    cnt_next  = db_cnt;
    cand_next = cand_key;
    accept    = 1'b0;
    if (frame_end) begin
      if (db_state == DB_ARMED) begin
        if (merged_hits == 2'd1) begin
          if (db_cnt != '0 && cand_key == merged_key) begin
            cnt_next = db_cnt + DB_W'(1);
          end else begin
            cnt_next  = DB_W'(1);
            cand_next = merged_key;
          end
          if (cnt_next == DB_W'(DEBOUNCE_SCANS)) begin
            accept   = 1'b1;
            db_next  = DB_HELD;
            cnt_next = '0;
          end
        end else begin
          cnt_next = '0;
        end
      end else begin
        if (merged_hits == 2'd0) begin
          cnt_next = db_cnt + DB_W'(1);
          if (cnt_next == DB_W'(DEBOUNCE_SCANS)) begin
            db_next  = DB_ARMED;
            cnt_next = '0;
          end
        end else begin
          cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_state  <= DB_ARMED;
      db_cnt    <= '0;
      cand_key  <= 4'h0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      db_state  <= db_next;
      db_cnt    <= cnt_next;
      cand_key  <= cand_next;
      key_valid <= accept;
      if (accept) key_code <= merged_key;
    end
  end

  // Entry FSM, acting on the same edge that raises key_valid
  entry_t     entry_st, st_next;
  logic [4:0] a_next, b_next;
  logic [1:0] op_next, key_op;
  logic       is_digit, is_op;

  assign is_digit = (merged_key <= 4'd9);
  assign is_op    = (merged_key >= 4'hA) && (merged_key <= 4'hD);
  assign key_op   = 2'(merged_key - 4'hA);

  always_comb begin
    st_next = entry_st;
    a_next  = operand_a;
    b_next  = operand_b;
    op_next = operator;
    if (accept && merged_key == KEY_F) begin
      st_next = ENTER_A;
      a_next  = 5'd0;
      b_next  = 5'd0;
      op_next = 2'b00;
    end else begin
      case (entry_st)
        ENTER_A: if (accept) begin
          if (is_digit) begin
            a_next = accumulate(operand_a, merged_key);
          end else if (is_op) begin
            op_next = key_op;
            b_next  = 5'd0;
            st_next = ENTER_B;
          end
        end
        ENTER_B: if (accept) begin
          if (is_digit)               b_next  = accumulate(operand_b, merged_key);
          else if (is_op)             op_next = key_op;
          else if (merged_key == KEY_E) st_next = SHOW;
        end
        SHOW: if (accept) begin
          if (is_digit) begin
            a_next  = 5'(merged_key);
            b_next  = 5'd0;
            st_next = ENTER_A;
          end else if (is_op) begin
            op_next = key_op;
            b_next  = 5'd0;
            st_next = ENTER_B;
          end
        end
        default: st_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_st  <= ENTER_A;
      operand_a <= 5'd0;
      operand_b <= 5'd0;
      operator  <= 2'b00;
    end else begin
      entry_st  <= st_next;
      operand_a <= a_next;
      operand_b <= b_next;
      operator  <= op_next;
    end
  end

  assign entry_state = entry_st;
  assign entry_valid = (entry_st == SHOW);

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a behavioural keypad drives the rows, and a scoreboard
// queue holds the expected result of every press until key_valid appears.
module tb_keypad_entry;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int FRAME          = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row, col;
  logic [4:0] operand_a, operand_b;
  logic [1:0] operator, entry_state;
  logic       entry_valid, key_valid;
  logic [3:0] key_code;

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .operand_a(operand_a), .operand_b(operand_b), .operator(operator),
    .entry_state(entry_state), .entry_valid(entry_valid),
    .key_valid(key_valid), .key_code(key_code)
  );

  // Keypad model: held[code] pulls its row low while its column is driven low.
  logic [15:0] held;

  function automatic logic [3:0] pad_key(input int r, input int c);
    case (r * 4 + c)
      0: return 4'h1;   1: return 4'h2;   2: return 4'h3;   3: return 4'hA;
      4: return 4'h4;   5: return 4'h5;   6: return 4'h6;   7: return 4'hB;
      8: return 4'h7;   9: return 4'h8;  10: return 4'h9;  11: return 4'hC;
     12: return 4'h0;  13: return 4'hF;  14: return 4'hE;  default: return 4'hD;
    endcase
  endfunction

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[pad_key(r, c)] && !col[c]) row[r] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] code;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] op;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst === 1'b0 && key_valid) begin
      pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("key_code",    32'(key_code),    32'(mon_e.code));
        check("operand_a",   32'(operand_a),   32'(mon_e.a));
        check("operand_b",   32'(operand_b),   32'(mon_e.b));
        check("operator",    32'(operator),    32'(mon_e.op));
        check("entry_state", 32'(entry_state), 32'(mon_e.st));
        check("entry_valid", 32'(entry_valid), 32'(mon_e.st == 2'd2));
      end
    end
  end

  task automatic press_key(input logic [3:0] code, input int hold_f, input int rel_f);
    held[code] = 1'b1;
    repeat (hold_f * FRAME) @(negedge clk);
    held[code] = 1'b0;
    repeat (rel_f * FRAME) @(negedge clk);
  endtask

  exp_t       vecs[16];
  logic [3:0] col_seq[4];
  int         base;

  initial begin
    vecs[0]  = '{4'h1, 5'd1,  5'd0, 2'd0, 2'd0};
    vecs[1]  = '{4'h2, 5'd12, 5'd0, 2'd0, 2'd0};
    vecs[2]  = '{4'hA, 5'd12, 5'd0, 2'd0, 2'd1};
    vecs[3]  = '{4'h7, 5'd12, 5'd7, 2'd0, 2'd1};
    vecs[4]  = '{4'hE, 5'd12, 5'd7, 2'd0, 2'd2};
    vecs[5]  = '{4'hC, 5'd12, 5'd0, 2'd2, 2'd1};
    vecs[6]  = '{4'hF, 5'd0,  5'd0, 2'd0, 2'd0};
    vecs[7]  = '{4'h4, 5'd4,  5'd0, 2'd0, 2'd0};
    vecs[8]  = '{4'h5, 5'd31, 5'd0, 2'd0, 2'd0};
    vecs[9]  = '{4'h9, 5'd31, 5'd0, 2'd0, 2'd0};
    vecs[10] = '{4'hE, 5'd31, 5'd0, 2'd0, 2'd0};
    vecs[11] = '{4'hD, 5'd31, 5'd0, 2'd3, 2'd1};
    vecs[12] = '{4'h3, 5'd31, 5'd3, 2'd3, 2'd1};
    vecs[13] = '{4'hB, 5'd31, 5'd3, 2'd1, 2'd1};
    vecs[14] = '{4'hE, 5'd31, 5'd3, 2'd1, 2'd2};
    vecs[15] = '{4'h5, 5'd5,  5'd0, 2'd1, 2'd0};
    col_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    held = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col",         32'(col),         32'hE);
    check("rst_operand_a",   32'(operand_a),   32'd0);
    check("rst_operand_b",   32'(operand_b),   32'd0);
    check("rst_operator",    32'(operator),    32'd0);
    check("rst_entry_state", 32'(entry_state), 32'd0);
    check("rst_entry_valid", 32'(entry_valid), 32'd0);
    check("rst_key_valid",   32'(key_valid),   32'd0);
    check("rst_key_code",    32'(key_code),    32'd0);

    // Column rotation straight out of reset
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("col_scan", 32'(col), 32'(col_seq[(i / 4) % 4]));
      @(negedge clk);
    end
    repeat (4 * FRAME) @(negedge clk);
    check("idle_no_pulse", pulses, 0);
    check("idle_operand_a", 32'(operand_a), 32'd0);

    // Main entry sequence
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back(vecs[i]);
      press_key(vecs[i].code, 3, 4);
      check("sb_drained", sb_q.size(), 0);
      if (i == 4) begin
        check("pulses_after_12A7E", pulses, 5);
        check("show_entry_valid", 32'(entry_valid), 32'd1);
      end
    end

    // Bouncing key 3 followed by a long hold
    base = pulses;
    sb_q.push_back('{4'h3, 5'd31, 5'd0, 2'd1, 2'd0});
    repeat (3) begin
      held[3] = 1'b1;
      repeat (FRAME) @(negedge clk);
      held[3] = 1'b0;
      repeat (FRAME) @(negedge clk);
    end
    held[3] = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    check("bounce_one_pulse", pulses - base, 1);
    repeat (20 * FRAME) @(negedge clk);
    held[3] = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    check("hold_no_repeat", pulses - base, 1);
    check("bounce_sb_drained", sb_q.size(), 0);

    // Two keys together never qualify; a clean single press afterwards does
    base = pulses;
    held[5] = 1'b1;
    held[9] = 1'b1;
    repeat (5 * FRAME) @(negedge clk);
    held[5] = 1'b0;
    held[9] = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("multi_no_pulse", pulses - base, 0);
    sb_q.push_back('{4'h9, 5'd31, 5'd0, 2'd1, 2'd0});
    press_key(4'h9, 3, 4);
    check("after_multi_pulse", pulses - base, 1);
    check("multi_sb_drained", sb_q.size(), 0);

    // Reset in the middle of debouncing key 8
    base = pulses;
    held[8] = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_col",       32'(col),       32'hE);
    check("midrst_key_code",  32'(key_code),  32'd0);
    check("midrst_operand_a", 32'(operand_a), 32'd0);
    check("midrst_operator",  32'(operator),  32'd0);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    held[8] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6 * FRAME) @(negedge clk);
    check("midrst_no_pulse", pulses - base, 0);
    check("midrst_state", 32'(entry_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart to the calculator's seven-segment output path: scans a 4x4 matrix keypad (Pmod KYPD wiring), debounces keys and assembles operand_a, operand_b and operator for alien_calculator.
- Replaces slide-switch entry. Sits between the board keypad pins and the calculator; its outputs feed the calculator and refresh_up_counter unchanged.

Parameters:
- SCAN_DIV, 100000: clocks each column is driven low (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scan frames needed to accept a press or a release.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- row  input  4  keypad rows, active-low, externally pulled up
- col  output 4  keypad columns, active-low, exactly one low at a time
- operand_a  output 5  first operand, 0..31
- operand_b  output 5  second operand, 0..31
- operator  output 2  00 add, 01 sub, 10 mul, 11 div
- entry_state  output 2  00 ENTER_A, 01 ENTER_B, 10 SHOW
- entry_valid  output 1  high while in SHOW
- key_valid  output 1  one-clock pulse per accepted press
- key_code  output 4  code of the last accepted key

Behaviour:
- Reset values (asynchronous):
  - col=4'b1110
  - operand_a, operand_b, operator, key_code = 0
  - key_valid=0, entry_valid=0, entry_state=ENTER_A
  - scan counters and debounce state cleared
- Row synchronisation: row passes through a 2-flop synchroniser before use.
- Column scan:
  - Columns rotate col0→col1→col2→col3→col0, each low for SCAN_DIV clocks.
  - Rows are sampled on the last clock of each column period.
  - One frame is four column periods.
- Key map, col0..col3 × row0..row3:
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: 0, F, E, D
  - key_code is 0x0–0x9 for digits and 0xA–0xF for letters.
- Frame result:
  - NONE if no row is low in any column.
  - The single key if exactly one row/column intersection is low.
  - MULTI (treated as NONE for acceptance, and blocks re-arm) if more than one.
- Debounce:
  - Idle→pressed requires DEBOUNCE_SCANS consecutive frames with the same single key.
  - On acceptance, key_valid pulses for one clock on the clock after the qualifying frame ends, and key_code updates at the same time.
  - No further press is accepted until DEBOUNCE_SCANS consecutive NONE frames occur; holding a key never repeats.
  - A differing key mid-count restarts the count with the new key.
- Digit accumulation: operand ← min(operand*10 + d, 31), computed at 9 bits, then saturated.
- Entry FSM (acts on the key_valid clock; outputs update the same edge):
  - ENTER_A:
    - digit → accumulate into operand_a.
    - A/B/C/D → operator=00/01/10/11, operand_b=0, go ENTER_B.
    - E → ignored.
  - ENTER_B:
    - digit → accumulate into operand_b.
    - A–D → replace operator, stay.
    - E → go SHOW.
  - SHOW (entry_valid=1):
    - digit d → operand_a=d, operand_b=0, operator unchanged, go ENTER_A.
    - A–D → keep operand_a, set operator, operand_b=0, go ENTER_B.
    - E → ignored.
  - F in any state → operand_a=operand_b=0, operator=00, go ENTER_A.
- Reset mid-scan or mid-debounce: everything returns to reset values immediately; any partially counted press is discarded.
- entry_state 2'b11 is unreachable; if reached, the FSM recovers to ENTER_A on the next clock.

Test Plan:
- Bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=2.
- Reset release, no key → col cycles 1110,1101,1011,0111 every 4 clocks; key_valid never asserts; all outputs 0.
- Press 1, 2, then A, then 7, then E (each held ≥3 frames, released ≥3 frames) → operand_a=12, operator=00, operand_b=7, entry_state=10, entry_valid=1, exactly 5 key_valid pulses.
- Press 4, 5 in ENTER_A → operand_a saturates at 31 (4→4, 5→31); 9 then gives 31.
- Bounce: key 3 asserted for 1 frame, released 1 frame, repeated 3 times, then held 2 frames → exactly one key_valid with key_code=3; holding 20 frames adds no pulses.
- Keys 5 and 9 held together for 5 frames → no key_valid; release both 2 frames, then press 9 → one pulse with key_code=9.
- In SHOW with operand_a=12: press C → entry_state=01, operator=10, operand_b=0, operand_a=12. Then press F → all zero, ENTER_A. Then assert rst mid-debounce of key 8 → no pulse is produced after rst deasserts.
